// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl
// Brief    : Cache-miss block fill sequencer. Latches the block-aligned miss
//            address, issues one memory read per cycle for every word of the
//            block, writes returning words into the data array in order and
//            strobes the tag array once the block is complete.
// Revision : 1.0  initial release
// ============================================================================
module cache_fill_ctrl #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int WORD_BYTES      = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_WIDTH-1:0]              miss_address,
    input  logic                               memory_data_valid,
    output logic                               fsm_busy,
    output logic                               memory_read_en,
    output logic [ADDR_WIDTH-1:0]              memory_address,
    output logic                               data_write_en,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_offset,
    output logic                               write_tag_array
);

    localparam int c_OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int c_CNT_W = c_OFF_W + 1;
    localparam int c_WB_SH = $clog2(WORD_BYTES);

    localparam logic [c_CNT_W-1:0]    c_WPB      = c_CNT_W'(WORDS_PER_BLOCK);
    localparam logic [c_CNT_W-1:0]    c_WPB_M1   = c_CNT_W'(WORDS_PER_BLOCK - 1);
    // Clears the byte-within-block bits so the base is block aligned.
    localparam logic [ADDR_WIDTH-1:0] c_BLK_MASK = ~ADDR_WIDTH'(WORDS_PER_BLOCK * WORD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_TAG  = 2'b10
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [c_CNT_W-1:0]      r_issue_cnt;
    logic [c_CNT_W-1:0]      r_recv_cnt;
    logic                    w_issue;
    logic                    w_write;
    logic [ADDR_WIDTH-1:0]   w_addr_off;

    // Byte offset of the word being requested; always inside the block, so the
    // add below can never carry out of the block-aligned base.
    assign w_addr_off = ADDR_WIDTH'(r_issue_cnt) << c_WB_SH;

    // State register; reset parks the controller in IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt      = ST_IDLE;
        w_issue          = 1'b0;
        w_write          = 1'b0;
        fsm_busy         = 1'b0;
        write_tag_array  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                fsm_busy    = miss_detected;
                w_state_nxt = miss_detected ? ST_FILL : ST_IDLE;
            end
            ST_FILL: begin
                fsm_busy    = 1'b1;
                w_issue     = (r_issue_cnt < c_WPB);
                w_write     = memory_data_valid && (r_recv_cnt < c_WPB);
                w_state_nxt = (w_write && (r_recv_cnt == c_WPB_M1)) ? ST_TAG : ST_FILL;
            end
            ST_TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        memory_read_en   = w_issue;
        memory_address   = w_issue ? (r_base + w_addr_off) : '0;
        data_write_en    = w_write;
        data_word_offset = w_write ? r_recv_cnt[c_OFF_W-1:0] : '0;
    end

    // Block base and issue/receive counters; the base is only captured in IDLE
    // so miss inputs seen during a fill have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else if ((r_state == ST_IDLE) && miss_detected) begin
            r_base      <= miss_address & c_BLK_MASK;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else if (r_state == ST_FILL) begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_write) begin
                r_recv_cnt <= r_recv_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_ctrl
// Brief    : Scoreboard bench for cache_fill_ctrl. The driver computes each
//            expected read address, write offset and tag strobe (with the
//            cycle it must appear in) from the block rules and queues them;
//            a negedge monitor pops and compares whenever the DUT fires.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_fill_ctrl;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } ev_t;

    // Queue index: 3*sel + {0: read address, 1: write offset, 2: tag strobe}
    ev_t q [6][$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_v  [2];
    logic [31:0] addr_v  [2];
    logic        valid_v [2];
    logic        exp_busy[2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        busy0, rd0, we0, tag0;
    logic [15:0] maddr0;
    logic [2:0]  off0;
    logic        busy1, rd1, we1, tag1;
    logic [31:0] maddr1;
    logic [1:0]  off1;

    cache_fill_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_v[0]),
        .miss_address      (addr_v[0][15:0]),
        .memory_data_valid (valid_v[0]),
        .fsm_busy          (busy0),
        .memory_read_en    (rd0),
        .memory_address    (maddr0),
        .data_write_en     (we0),
        .data_word_offset  (off0),
        .write_tag_array   (tag0)
    );

    cache_fill_ctrl #(.ADDR_WIDTH(32), .WORDS_PER_BLOCK(4), .WORD_BYTES(4)) dut32 (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_v[1]),
        .miss_address      (addr_v[1]),
        .memory_data_valid (valid_v[1]),
        .fsm_busy          (busy1),
        .memory_read_en    (rd1),
        .memory_address    (maddr1),
        .data_write_en     (we1),
        .data_word_offset  (off1),
        .write_tag_array   (tag1)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle N is the interval after the Nth rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int qi, input int c, input logic [63:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        q[qi].push_back(e);
    endtask

    // Pops one expected event when the DUT fires; flags expectations whose
    // cycle has passed without the DUT producing them.
    task automatic mon(input int qi, input string nm, input logic fired, input logic [63:0] act);
        ev_t e;
        while (q[qi].size() > 0 && q[qi][0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missing: actual=none expected=%0h due cycle %0d", nm, q[qi][0].val, q[qi][0].cyc);
            void'(q[qi].pop_front());
        end
        if (fired) begin
            if (q[qi].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected at cycle %0d: actual=%0h expected=none", nm, cyc, act);
            end else begin
                e = q[qi].pop_front();
                chk({nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk(nm, act, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        chk("fsm_busy", 64'(busy0), 64'(exp_busy[0]));
        mon(0, "rd_addr", rd0, 64'(maddr0));
        if (!rd0) chk("addr_when_idle", 64'(maddr0), 64'd0);
        mon(1, "wr_offset", we0, 64'(off0));
        mon(2, "tag_strobe", tag0, 64'd1);
        chk("fsm_busy32", 64'(busy1), 64'(exp_busy[1]));
        mon(3, "rd_addr32", rd1, 64'(maddr1));
        if (!rd1) chk("addr_when_idle32", 64'(maddr1), 64'd0);
        mon(4, "wr_offset32", we1, 64'(off1));
        mon(5, "tag_strobe32", tag1, 64'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < 2; s++) begin
                miss_v[s]   = 1'b0;
                valid_v[s]  = 1'b0;
                exp_busy[s] = 1'b0;
            end
            step();
        end
    endtask

    // One full block fill on DUT sel. mode 0: each word returns 4 cycles after
    // its request; mode 1: in-order returns with random 0-5 cycle gaps.
    // hold keeps a miss for next_addr asserted from the TAG cycle onward.
    task automatic do_fill(input int sel, input logic [31:0] addr, input int mode,
                           input bit hold, input logic [31:0] next_addr);
        int          n    = (sel != 0) ? 4 : 8;
        int          wb   = (sel != 0) ? 4 : 2;
        logic [31:0] amsk = (sel != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        logic [31:0] base = addr & ~(32'(n * wb) - 32'd1) & amsk;
        int          k    = cyc;
        int          recv = 0;
        int          gap  = $urandom_range(0, 5);
        int          avail;
        int          c;
        bit          v;
        miss_v[sel]   = 1'b1;
        addr_v[sel]   = addr;
        valid_v[sel]  = 1'b0;
        exp_busy[sel] = 1'b1;
        for (int i = 0; i < n; i++) push(3 * sel, k + 1 + i, 64'((base + 32'(i * wb)) & amsk));
        step();
        while (1) begin
            c = cyc;
            miss_v[sel] = 1'($urandom_range(0, 1));
            addr_v[sel] = $urandom;
            avail = (c - (k + 1) < n) ? c - (k + 1) : n;
            v = 1'b0;
            if (mode == 0) begin
                v = (c == k + 5 + recv);
            end else if (recv < avail) begin
                if (gap == 0) begin
                    v   = 1'b1;
                    gap = $urandom_range(0, 5);
                end else begin
                    gap--;
                end
            end
            valid_v[sel] = v;
            if (v) begin
                push(3 * sel + 1, c, 64'(recv));
                recv++;
            end
            if (recv == n) break;
            if (c - k > 200) begin
                chk("fill_bound", 64'(recv), 64'(n));
                break;
            end
            step();
        end
        step();
        // TAG cycle: surplus valid and any miss input must be ignored.
        push(3 * sel + 2, cyc, 64'd1);
        valid_v[sel] = 1'b1;
        miss_v[sel]  = hold;
        addr_v[sel]  = next_addr;
        step();
        if (!hold) begin
            // IDLE cycle: a stray valid must not write anything.
            miss_v[sel]   = 1'b0;
            valid_v[sel]  = 1'b1;
            exp_busy[sel] = 1'b0;
            step();
            valid_v[sel]  = 1'b0;
        end
    endtask

    // Starts a fill, returns three words, then pulls reset mid-fill.
    task automatic do_abort(input logic [31:0] addr);
        int k = cyc;
        miss_v[0]   = 1'b1;
        addr_v[0]   = addr;
        valid_v[0]  = 1'b0;
        exp_busy[0] = 1'b1;
        for (int i = 0; i < 8; i++) push(0, k + 1 + i, 64'(((addr & 32'hFFF0) + 32'(2 * i)) & 32'hFFFF));
        step();
        miss_v[0] = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            valid_v[0] = 1'b1;
            push(1, cyc, 64'(i));
            step();
        end
        valid_v[0] = 1'b0;
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) q[i].delete();
        exp_busy[0] = 1'b0;
        #1;
        chk("rst_read_en", 64'(rd0), 64'd0);
        chk("rst_addr", 64'(maddr0), 64'd0);
        chk("rst_write_en", 64'(we0), 64'd0);
        chk("rst_tag", 64'(tag0), 64'd0);
        chk("rst_busy_nomiss", 64'(busy0), 64'd0);
        miss_v[0]   = 1'b1;
        exp_busy[0] = 1'b1;
        #1;
        chk("rst_busy_miss", 64'(busy0), 64'd1);
        step();
        valid_v[0] = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            miss_v[s]   = 1'b0;
            addr_v[s]   = '0;
            valid_v[s]  = 1'b0;
            exp_busy[s] = 1'b0;
        end
        step();
        step();
        rst_n = 1'b1;
        idle(2);
        do_fill(0, 32'h1234, 0, 1'b0, 32'h0);
        idle(1);
        for (int t = 0; t < 4; t++) begin
            do_fill(0, $urandom, 1, 1'b0, 32'h0);
            idle($urandom_range(0, 2));
        end
        do_abort(32'h5678);
        do_fill(0, 32'hABC0, 1, 1'b0, 32'h0);
        idle(1);
        do_fill(0, 32'h1F00, 1, 1'b1, 32'h2000);
        do_fill(0, 32'h2000, 0, 1'b0, 32'h0);
        idle(2);
        do_fill(1, 32'hFFFF_FFFA, 0, 1'b0, 32'h0);
        idle(1);
        do_fill(1, $urandom, 1, 1'b0, 32'h0);
        idle(3);
        for (int i = 0; i < 6; i++) chk("queue_drained", 64'(q[i].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
